// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared definitions for the fetch-path instruction-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_mem_arbiter_pkg;

    // Transaction FSM encodings; the values are fixed so waveforms stay readable across revisions.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/fetch_mem_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first active request after 'last', searching cyclically.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
// Ports:
//   req     in   NUM_REQ  active requests
//   last    in   IDX_W    index that won most recently (lowest priority this round)
//   gnt     out  NUM_REQ  one-hot grant, zero when no request is active
//   gnt_idx out  IDX_W    binary index of the granted request (0 when none)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        logic found;
        int   cand;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Offsets 1..NUM_REQ visit every requester once, ending on 'last' itself.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one instruction-memory port between NUM_REQ fetch requesters, one transaction at a time.
// Latency: grant T, mem_request_o T+1, response pulse the cycle after mem_dataOk_i; next grant same cycle as the pulse.
// Backpressure: req_ready_o only in IDLE without jumpFlag_i; flushed/late responses are swallowed, watchdog aborts stuck fetches.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_valid_i/req_addr_i     per-requester fetch request and address (slice k = [k*ADDR_W +: ADDR_W])
//   req_ready_o                one-hot combinational grant
//   rsp_valid_o/rsp_inst_o     one-cycle response pulse to the owner with the instruction word
//   jumpFlag_i                 pipeline flush; kills the in-flight transaction
//   mem_request_o/mem_instAddr_o/mem_inst_i/mem_dataOk_i  memory handshake
//   busy_o, err_timeout_o      transaction outstanding; sticky watchdog flag
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_inst_o,
    input  logic                      jumpFlag_i,
    output logic                      mem_request_o,
    output logic [ADDR_W-1:0]         mem_instAddr_o,
    input  logic [DATA_W-1:0]         mem_inst_i,
    input  logic                      mem_dataOk_i,
    output logic                      busy_o,
    output logic                      err_timeout_o
);

    localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    rr_last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                mem_req_q;
    logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]   rsp_inst_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                err_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                grant_en;
    logic                grant_any;
    logic [ADDR_W-1:0]   grant_addr;
    logic                deliver;
    logic                timeout_hit;
    logic                cnt_at_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req_valid_i),
        .last    (rr_last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Reset also masks the grant so no requester believes it was accepted during a reset cycle.
    assign grant_en    = (state_q == ARB_IDLE) && !jumpFlag_i && !reset;
    assign req_ready_o = grant_en ? arb_gnt : '0;
    assign grant_any   = |req_ready_o;
    assign grant_addr  = req_addr_i[int'(arb_idx) * ADDR_W +: ADDR_W];
    assign cnt_at_last = (wait_cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        deliver     = 1'b0;
        timeout_hit = 1'b0;
        rsp_vld_d   = '0;
        case (state_q)
            ARB_IDLE: begin
                // A dataOk pulse here is spurious and deliberately ignored.
                if (grant_any) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_dataOk_i) begin
                    // A flush in the same cycle as the data discards it.
                    state_d = ARB_IDLE;
                    deliver = !jumpFlag_i;
                end else if (cnt_at_last) begin
                    state_d     = ARB_IDLE;
                    timeout_hit = 1'b1;
                end else if (jumpFlag_i) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // The memory still owes one response; wait it out. Further flushes change nothing.
                if (mem_dataOk_i) begin
                    state_d = ARB_IDLE;
                end else if (cnt_at_last) begin
                    state_d     = ARB_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (deliver) begin
            rsp_vld_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_last_q  <= LAST_RST;
            addr_q     <= '0;
            mem_req_q  <= 1'b0;
            rsp_vld_q  <= '0;
            rsp_inst_q <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= grant_any;
            rsp_vld_q  <= rsp_vld_d;
            rsp_inst_q <= deliver ? mem_inst_i : '0;
            if (grant_any) begin
                owner_q <= arb_idx;
                addr_q  <= grant_addr;
            end
            // Fairness only advances on a delivered response.
            if (deliver) begin
                rr_last_q <= owner_q;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if ((state_q == ARB_IDLE) || (state_d == ARB_IDLE)) begin
                wait_cnt_q <= '0;
            end else if (!cnt_at_last) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign rsp_valid_o    = rsp_vld_q;
    assign rsp_inst_o     = rsp_inst_q;
    assign mem_request_o  = mem_req_q;
    assign mem_instAddr_o = addr_q;
    assign busy_o         = (state_q != ARB_IDLE);
    assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: single fetch, fairness, flushes, timeout, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_mem_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]         rsp_inst_o;
    logic                      jumpFlag_i;
    logic                      mem_request_o;
    logic [ADDR_W-1:0]         mem_instAddr_o;
    logic [DATA_W-1:0]         mem_inst_i;
    logic                      mem_dataOk_i;
    logic                      busy_o;
    logic                      err_timeout_o;

    int errors = 0;
    int checks = 0;

    fetch_mem_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_addr_i     (req_addr_i),
        .req_ready_o    (req_ready_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_inst_o     (rsp_inst_o),
        .jumpFlag_i     (jumpFlag_i),
        .mem_request_o  (mem_request_o),
        .mem_instAddr_o (mem_instAddr_o),
        .mem_inst_i     (mem_inst_i),
        .mem_dataOk_i   (mem_dataOk_i),
        .busy_o         (busy_o),
        .err_timeout_o  (err_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        req_valid_i  = '0;
        req_addr_i   = '0;
        jumpFlag_i   = 1'b0;
        mem_inst_i   = '0;
        mem_dataOk_i = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_memreq", mem_request_o, 0);
        chk("rst_rsp", rsp_valid_o, 0);
        chk("rst_err", err_timeout_o, 0);
        chk("rst_addr", mem_instAddr_o, 0);

        // ---- 1: single fetch from requester 0 ----
        reset = 1'b0;
        req_valid_i = 2'b01;
        req_addr_i  = {32'h0000_0300, 32'h0000_0100};
        settle();
        chk("t1_grant", req_ready_o, 2'b01);
        tick();                                   // T+1
        req_valid_i = 2'b00;
        settle();
        chk("t1_memreq", mem_request_o, 1);
        chk("t1_addr", mem_instAddr_o, 32'h100);
        chk("t1_busy", busy_o, 1);
        chk("t1_noready", req_ready_o, 0);
        tick();                                   // T+2
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'hDEAD_BEEF;
        settle();
        chk("t1_req_pulse", mem_request_o, 0);
        chk("t1_addr_hold", mem_instAddr_o, 32'h100);
        tick();                                   // T+3
        mem_dataOk_i = 1'b0;
        settle();
        chk("t1_rsp", rsp_valid_o, 2'b01);
        chk("t1_inst", rsp_inst_o, 32'hDEAD_BEEF);
        chk("t1_idle", busy_o, 0);
        tick();
        chk("t1_rsp_pulse", rsp_valid_o, 0);

        // ---- 2: fairness, both always valid; requester 0 won last so 1,0,1,0 ----
        req_valid_i = 2'b11;
        req_addr_i  = {32'h0000_0300, 32'h0000_0200};
        settle();
        for (int i = 0; i < 4; i++) begin
            int exp_k;
            exp_k = (i % 2 == 0) ? 1 : 0;
            chk("t2_grant", req_ready_o, 64'(1) << exp_k);
            tick();
            settle();
            chk("t2_memreq", mem_request_o, 1);
            chk("t2_addr", mem_instAddr_o, (exp_k == 1) ? 32'h300 : 32'h200);
            mem_dataOk_i = 1'b1;
            mem_inst_i   = 32'h0000_1000 + 32'(i);
            tick();
            mem_dataOk_i = 1'b0;
            if (i == 3) begin
                req_valid_i = 2'b00;
            end
            settle();
            chk("t2_rsp", rsp_valid_o, 64'(1) << exp_k);
            chk("t2_inst", rsp_inst_o, 32'h0000_1000 + 32'(i));
        end
        chk("t2_idle_noready", req_ready_o, 0);

        // ---- 3: flush in WAIT, late dataOk swallowed ----
        tick();
        req_valid_i = 2'b11;
        settle();
        chk("t3_grant", req_ready_o, 2'b10);
        tick();                                   // F+1
        req_valid_i = 2'b00;
        settle();
        chk("t3_memreq", mem_request_o, 1);
        tick();                                   // F+2
        jumpFlag_i = 1'b1;
        settle();
        tick();                                   // F+3 (DRAIN)
        jumpFlag_i = 1'b0;
        settle();
        chk("t3_drain_busy", busy_o, 1);
        chk("t3_drain_rsp", rsp_valid_o, 0);
        tick();                                   // F+4
        jumpFlag_i = 1'b1;                        // ignored while draining
        settle();
        tick();                                   // F+5
        jumpFlag_i   = 1'b0;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h0BAD_0BAD;
        settle();
        chk("t3_still_busy", busy_o, 1);
        tick();                                   // F+6
        mem_dataOk_i = 1'b0;
        req_valid_i  = 2'b11;
        settle();
        chk("t3_idle", busy_o, 0);
        chk("t3_no_rsp", rsp_valid_o, 0);
        chk("t3_rr_unchanged", req_ready_o, 2'b10);

        // ---- 4: jumpFlag and dataOk together in WAIT ----
        tick();
        req_valid_i = 2'b00;
        settle();
        chk("t4_memreq", mem_request_o, 1);
        tick();
        jumpFlag_i   = 1'b1;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'h1234_5678;
        settle();
        tick();
        mem_dataOk_i = 1'b0;
        req_valid_i  = 2'b01;
        settle();
        chk("t4_no_rsp", rsp_valid_o, 0);
        chk("t4_idle", busy_o, 0);
        chk("t4_jump_blocks", req_ready_o, 0);
        tick();
        jumpFlag_i  = 1'b0;
        req_valid_i = 2'b11;
        settle();
        chk("t4_no_grant_taken", busy_o, 0);
        chk("t4_rr_unchanged", req_ready_o, 2'b10);

        // ---- 5: watchdog, memory never answers ----
        tick();                                   // first WAIT cycle
        req_valid_i = 2'b00;
        settle();
        chk("t5_memreq", mem_request_o, 1);
        for (int c = 0; c < 8; c++) begin
            chk("t5_waiting", {busy_o, err_timeout_o}, 2'b10);
            tick();
        end
        req_valid_i = 2'b11;
        settle();
        chk("t5_err", err_timeout_o, 1);
        chk("t5_idle", busy_o, 0);
        chk("t5_no_rsp", rsp_valid_o, 0);
        chk("t5_rr_unchanged", req_ready_o, 2'b10);
        tick();
        req_valid_i = 2'b00;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'hCAFE_0001;
        settle();
        chk("t5_new_req", mem_request_o, 1);
        tick();
        mem_dataOk_i = 1'b0;
        req_valid_i  = 2'b01;
        settle();
        chk("t5_rsp", rsp_valid_o, 2'b10);
        chk("t5_err_sticky", err_timeout_o, 1);
        chk("t5_grant0", req_ready_o, 2'b01);
        tick();
        req_valid_i  = 2'b00;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'hCAFE_0002;
        settle();
        tick();
        mem_dataOk_i = 1'b0;
        req_valid_i  = 2'b11;
        settle();
        chk("t5_rsp0", rsp_valid_o, 2'b01);
        chk("t5_grant1", req_ready_o, 2'b10);

        // ---- 6: reset mid-WAIT, then spurious dataOk in IDLE ----
        tick();
        settle();
        chk("t6_wait", busy_o, 1);
        reset        = 1'b1;
        mem_dataOk_i = 1'b1;
        mem_inst_i   = 32'hFFFF_0000;
        settle();
        tick();
        reset = 1'b0;
        req_valid_i = 2'b00;
        settle();
        chk("t6_busy", busy_o, 0);
        chk("t6_rsp", rsp_valid_o, 0);
        chk("t6_inst", rsp_inst_o, 0);
        chk("t6_memreq", mem_request_o, 0);
        chk("t6_addr", mem_instAddr_o, 0);
        chk("t6_err", err_timeout_o, 0);
        tick();
        mem_dataOk_i = 1'b0;
        req_valid_i  = 2'b11;
        settle();
        chk("t6_spur_busy", busy_o, 0);
        chk("t6_spur_rsp", rsp_valid_o, 0);
        chk("t6_spur_memreq", mem_request_o, 0);
        chk("t6_rr_reset", req_ready_o, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
